hamming_best_match: RTL and testbench

Sequential frame scorer that sits directly downstream of `hammingbenzer4bit`. It latches a 4-bit reference pattern, then accepts a frame of `N` 4-bit candidate words over a valid/ready stream. Each candidate is scored with an internal `hammingbenzer4bit` instance, where the score is the count of equal bit positions (0..4). The block reports the best-scoring candidate index, its score, and how many candidates matched exactly, with a one-cycle completion pulse.

---
 rtl/hamming_best_match.sv | 112 +++++++++++
 tb/tb_hamming_best_match.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/hamming_best_match.sv
// rtl/hamming_best_match.sv - frame scorer picking the candidate closest to a latched reference
module hammingbenzer4bit (
  input  logic [3:0] A,
  input  logic [3:0] B,
  output logic [2:0] HB
);
  logic [3:0] eq;

  always_comb begin
    eq = ~(A ^ B);
    HB = 3'(eq[0]) + 3'(eq[1]) + 3'(eq[2]) + 3'(eq[3]);
  end
endmodule

module hamming_best_match #(
  parameter int N     = 8,
  parameter int IDX_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       ref_in,
  input  logic             cand_valid,
  input  logic [3:0]       cand_data,
  output logic             cand_ready,
  output logic             busy,
  output logic             done,
  output logic [IDX_W-1:0] best_idx,
  output logic [2:0]       best_hb,
  output logic [IDX_W:0]   exact_cnt
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [3:0]       ref_reg_q, ref_reg_d;
  logic [IDX_W:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0] best_idx_q, best_idx_d;
  logic [2:0]       best_hb_q, best_hb_d;
  logic [IDX_W:0]   exact_cnt_q, exact_cnt_d;
  logic [2:0]       hb;
  logic             hs;

  hammingbenzer4bit u_score (
    .A  (ref_reg_q),
    .B  (cand_data),
    .HB (hb)
  );

  // Handshake qualifier uses only registered state, so cand_ready never depends on cand_valid.
  assign cand_ready = (state_q == S_RUN);
  assign done       = (state_q == S_DONE);
  assign busy       = (state_q != S_IDLE);
  assign hs         = cand_valid & cand_ready;
  assign best_idx   = best_idx_q;
  assign best_hb    = best_hb_q;
  assign exact_cnt  = exact_cnt_q;

  always_comb begin
    state_d     = state_q;
    ref_reg_d   = ref_reg_q;
    cnt_d       = cnt_q;
    best_idx_d  = best_idx_q;
    best_hb_d   = best_hb_q;
    exact_cnt_d = exact_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d     = S_RUN;
          ref_reg_d   = ref_in;
          cnt_d       = '0;
          best_idx_d  = '0;
          best_hb_d   = '0;
          exact_cnt_d = '0;
        end
      end
      S_RUN: begin
        if (hs) begin
          cnt_d = cnt_q + 1'b1;
          // Strict greater-than keeps the earliest candidate on ties.
          if (cnt_q == '0 || hb > best_hb_q) begin
            best_hb_d  = hb;
            best_idx_d = cnt_q[IDX_W-1:0];
          end
          if (hb == 3'd4) exact_cnt_d = exact_cnt_q + 1'b1;
          if (cnt_q == (IDX_W+1)'(N-1)) state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      ref_reg_q   <= '0;
      cnt_q       <= '0;
      best_idx_q  <= '0;
      best_hb_q   <= '0;
      exact_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      ref_reg_q   <= ref_reg_d;
      cnt_q       <= cnt_d;
      best_idx_q  <= best_idx_d;
      best_hb_q   <= best_hb_d;
      exact_cnt_q <= exact_cnt_d;
    end
  end
endmodule

// File: tb/tb_hamming_best_match.sv
// tb/tb_hamming_best_match.sv - directed bench for hamming_best_match
module tb_hamming_best_match;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [3:0] ref_in;
  logic       cand_valid;
  logic [3:0] cand_data;
  logic       cand_ready;
  logic       busy;
  logic       done;
  logic [2:0] best_idx;
  logic [2:0] best_hb;
  logic [3:0] exact_cnt;

  int checks = 0;
  int errors = 0;

  hamming_best_match #(.N(8), .IDX_W(3)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .ref_in     (ref_in),
    .cand_valid (cand_valid),
    .cand_data  (cand_data),
    .cand_ready (cand_ready),
    .busy       (busy),
    .done       (done),
    .best_idx   (best_idx),
    .best_hb    (best_hb),
    .exact_cnt  (exact_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_start(input logic [3:0] r);
    start = 1'b1;
    ref_in = r;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Called at a negedge; returns at the negedge after the handshake edge.
  task automatic push(input logic [3:0] d);
    int t = 0;
    cand_valid = 1'b1;
    cand_data = d;
    while (!cand_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!cand_ready) chk("push_timeout", 8'(cand_ready), 8'd1);
    @(negedge clk);
  endtask

  task automatic run_frame(input logic [3:0] r, input logic [3:0] c [8], input int maxgap);
    do_start(r);
    for (int i = 0; i < 8; i++) begin
      if (maxgap > 0 && i > 0) begin
        int g = $urandom_range(0, maxgap);
        cand_valid = 1'b0;
        repeat (g) @(negedge clk);
      end
      push(c[i]);
    end
    cand_valid = 1'b0;
  endtask

  task automatic chk_res(input string tag, input logic [2:0] i, input logic [2:0] h, input logic [3:0] e);
    chk({tag, "_idx"}, 8'(best_idx), 8'(i));
    chk({tag, "_hb"}, 8'(best_hb), 8'(h));
    chk({tag, "_exact"}, 8'(exact_cnt), 8'(e));
  endtask

  logic [3:0] basic [8];
  logic [3:0] ones  [8];
  logic [3:0] alt   [8];
  logic [3:0] fresh [8];
  logic [3:0] lo    [8];
  logic [3:0] hi    [8];

  initial begin
    basic = '{4'b0000, 4'b1010, 4'b1011, 4'b0101, 4'b1010, 4'b1110, 4'b0010, 4'b1111};
    ones  = '{default: 4'b1111};
    alt   = '{4'b0001, 4'b0011, 4'b0001, 4'b0011, 4'b0001, 4'b0011, 4'b0001, 4'b0011};
    fresh = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b1100, 4'b1100};
    for (int i = 0; i < 8; i++) begin
      lo[i] = 4'(i);
      hi[i] = 4'(i + 8);
    end
    rst_n = 1'b0; start = 1'b0; ref_in = 4'h0; cand_valid = 1'b0; cand_data = 4'h0;
    repeat (2) @(negedge clk);
    chk("rst_ready", 8'(cand_ready), 8'd0);
    chk("rst_busy", 8'(busy), 8'd0);
    chk("rst_done", 8'(done), 8'd0);
    chk_res("rst", 3'd0, 3'd0, 4'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic frame with done pulse timing
    run_frame(4'b1010, basic, 0);
    chk("basic_done", 8'(done), 8'd1);
    chk("basic_busy", 8'(busy), 8'd1);
    chk("basic_ready_done", 8'(cand_ready), 8'd0);
    chk_res("basic", 3'd1, 3'd4, 4'd2);
    @(negedge clk);
    chk("basic_done_off", 8'(done), 8'd0);
    chk("basic_idle_busy", 8'(busy), 8'd0);
    chk_res("basic_hold", 3'd1, 3'd4, 4'd2);

    // Back-to-back: start accepted at k+2, results cleared
    do_start(4'b0000);
    chk("b2b_ready", 8'(cand_ready), 8'd1);
    chk_res("b2b_clear", 3'd0, 3'd0, 4'd0);
    for (int i = 0; i < 8; i++) push(ones[i]);
    cand_valid = 1'b0;
    chk("ties_done", 8'(done), 8'd1);
    chk_res("ties_zero", 3'd0, 3'd0, 4'd0);
    @(negedge clk);
    run_frame(4'b0000, alt, 0);
    chk_res("ties_three", 3'd0, 3'd3, 4'd0);
    @(negedge clk);

    // Stalls, with start pulses in RUN and in DONE
    do_start(4'b1010);
    push(basic[0]);
    cand_valid = 1'b0;
    repeat (3) @(negedge clk);
    push(basic[1]);
    cand_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk_res("stall_mid", 3'd1, 3'd4, 4'd1);
    chk("stall_ready", 8'(cand_ready), 8'd1);
    start = 1'b1; ref_in = 4'b1111;
    @(negedge clk);
    start = 1'b0;
    for (int i = 2; i < 8; i++) begin
      cand_valid = 1'b0;
      repeat ($urandom_range(0, 5)) @(negedge clk);
      push(basic[i]);
    end
    cand_valid = 1'b0;
    chk("stall_done", 8'(done), 8'd1);
    chk_res("stall", 3'd1, 3'd4, 4'd2);
    start = 1'b1; ref_in = 4'b1111;
    @(negedge clk);
    start = 1'b0;
    chk("done_start_busy", 8'(busy), 8'd0);
    chk("done_start_done", 8'(done), 8'd0);
    chk_res("done_start_hold", 3'd1, 3'd4, 4'd2);

    // Random-gap frame
    run_frame(4'b1010, basic, 5);
    chk_res("gaps", 3'd1, 3'd4, 4'd2);
    @(negedge clk);

    // Reset mid-RUN after three candidates
    do_start(4'b1010);
    for (int i = 0; i < 3; i++) push(basic[i]);
    cand_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_ready", 8'(cand_ready), 8'd0);
    chk("mid_rst_busy", 8'(busy), 8'd0);
    chk("mid_rst_done", 8'(done), 8'd0);
    chk_res("mid_rst", 3'd0, 3'd0, 4'd0);
    rst_n = 1'b1;
    @(negedge clk);
    run_frame(4'b1100, fresh, 0);
    chk_res("fresh", 3'd6, 3'd4, 4'd2);
    @(negedge clk);

    // Exhaustive: two frames per reference cover all 16 candidates
    for (int r = 0; r < 16; r++) begin
      logic [2:0] h_lo, h_hi;
      logic [3:0] e_lo;
      logic [2:0] i_lo, i_hi;
      run_frame(4'(r), lo, 0);
      h_lo = best_hb; i_lo = best_idx; e_lo = exact_cnt;
      @(negedge clk);
      run_frame(4'(r), hi, 0);
      h_hi = best_hb; i_hi = best_idx;
      chk("exh_exact_sum", 8'(e_lo + exact_cnt), 8'd1);
      chk("exh_hb_lo", 8'(h_lo), (r < 8) ? 8'd4 : 8'd3);
      chk("exh_hb_hi", 8'(h_hi), (r < 8) ? 8'd3 : 8'd4);
      chk("exh_idx_lo", 8'(i_lo), 8'(r % 8));
      chk("exh_idx_hi", 8'(i_hi), 8'(r % 8));
      @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
